// File: rtl/amp_freq_ctrl_if.sv
// amp_freq_ctrl_if: request inputs and amplitude/frequency status outputs of amp_freq_ctrl.
interface amp_freq_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             a_up;
    logic             a_down;
    logic             f_up;
    logic             f_down;
    logic             err_clr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] F;
    logic             F0;
    logic             A0;
    logic             busy;
    logic             error;

    modport master (
        output a_up, a_down, f_up, f_down, err_clr,
        input  A, F, F0, A0, busy, error
    );

    modport slave (
        input  a_up, a_down, f_up, f_down, err_clr,
        output A, F, F0, A0, busy, error
    );
endinterface

// File: rtl/amp_freq_ctrl.sv
// amp_freq_ctrl: edge-triggered saturating amplitude/frequency controller with automatic
// amplitude decay once frequency reaches zero.
module amp_freq_ctrl #(
    parameter int WIDTH     = 3,
    parameter int A_INIT    = 4,
    parameter int F_INIT    = 4,
    parameter int A_MAX     = 7,
    parameter int F_MAX     = 7,
    parameter int DECAY_DIV = 4
) (
    input logic            clk,
    input logic            reset,
    amp_freq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, DECAY, STOPPED} state_t;
    localparam int CW = $clog2(DECAY_DIV + 1);
    localparam logic [WIDTH-1:0] AMAX = WIDTH'(A_MAX);
    localparam logic [WIDTH-1:0] FMAX = WIDTH'(F_MAX);
    localparam logic [CW-1:0]    DMAX = CW'(DECAY_DIV - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n, f_q, f_n, a_step, f_step;
    logic [CW-1:0]    cnt, cnt_n;
    logic             err_q, err_n, err_set;
    logic [3:0]       req, prev, rise;
    logic             a_inc, a_dec, f_inc, f_dec, a_err, f_err;

    assign req  = {bus.a_up, bus.a_down, bus.f_up, bus.f_down};
    assign rise = req & ~prev;
    // Opposing edges in the same cycle cancel each other silently
    assign a_inc = rise[3] & ~rise[2];
    assign a_dec = rise[2] & ~rise[3];
    assign f_inc = rise[1] & ~rise[0];
    assign f_dec = rise[0] & ~rise[1];

    assign a_err  = (a_inc && a_q == AMAX) || (a_dec && a_q == '0);
    assign f_err  = (f_inc && f_q == FMAX) || (f_dec && f_q == '0);
    assign a_step = (a_inc && a_q != AMAX) ? a_q + 1'b1 : (a_dec && a_q != '0) ? a_q - 1'b1 : a_q;
    assign f_step = (f_inc && f_q != FMAX) ? f_q + 1'b1 : (f_dec && f_q != '0) ? f_q - 1'b1 : f_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            a_q   <= WIDTH'(A_INIT);
            f_q   <= WIDTH'(F_INIT);
            cnt   <= '0;
            err_q <= 1'b0;
            prev  <= '0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            f_q   <= f_n;
            cnt   <= cnt_n;
            err_q <= err_n;
            prev  <= req;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        f_n     = f_q;
        cnt_n   = cnt;
        err_set = 1'b0;
        case (state)
            RUN: begin
                a_n     = a_step;
                f_n     = f_step;
                err_set = a_err | f_err;
                // Leave RUN only when F is already zero and not being raised this edge
                if (f_q == '0 && f_step == '0) begin
                    state_n = (a_step != '0) ? DECAY : STOPPED;
                    cnt_n   = '0;
                end
            end
            DECAY: begin
                if (f_inc) begin
                    f_n     = WIDTH'(1);
                    state_n = RUN;
                    cnt_n   = '0;
                end else if (a_q == '0) begin
                    state_n = STOPPED;
                    cnt_n   = '0;
                end else if (cnt == DMAX) begin
                    a_n   = a_q - 1'b1;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOPPED: begin
                a_n     = a_step;
                err_set = a_err | f_dec;
                if (f_inc) begin
                    f_n     = WIDTH'(1);
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
        err_n = err_set | (err_q & ~bus.err_clr);
    end

    assign bus.A     = a_q;
    assign bus.F     = f_q;
    assign bus.A0    = (a_q == '0);
    assign bus.F0    = (f_q == '0);
    assign bus.busy  = (state == DECAY);
    assign bus.error = err_q;
endmodule

// File: tb/tb_amp_freq_ctrl.sv
// tb_amp_freq_ctrl: directed-vector bench for amp_freq_ctrl with default parameters.
module tb_amp_freq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    amp_freq_ctrl_if #(.WIDTH(3)) bus ();

    amp_freq_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        {bus.a_up, bus.a_down, bus.f_up, bus.f_down, bus.err_clr} = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // sel: 0=a_up 1=a_down 2=f_up 3=f_down; high for one edge, low for the next
    task automatic press(input int sel);
        case (sel)
            0: bus.a_up = 1'b1;
            1: bus.a_down = 1'b1;
            2: bus.f_up = 1'b1;
            default: bus.f_down = 1'b1;
        endcase
        tick();
        {bus.a_up, bus.a_down, bus.f_up, bus.f_down} = '0;
        tick();
    endtask

    initial begin
        {bus.a_up, bus.a_down, bus.f_up, bus.f_down, bus.err_clr} = '0;
        tick();
        chk("rst_A", 8'(bus.A), 8'd4);
        chk("rst_F", 8'(bus.F), 8'd4);
        chk("rst_F0", 8'(bus.F0), 8'd0);
        chk("rst_A0", 8'(bus.A0), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_error", 8'(bus.error), 8'd0);
        reset = 1'b0;

        bus.f_up = 1'b1;
        repeat (10) tick();
        chk("hold_F", 8'(bus.F), 8'd5);
        chk("hold_error", 8'(bus.error), 8'd0);
        bus.f_up = 1'b0;
        tick();

        do_reset();
        repeat (3) press(2);
        chk("sat_F7", 8'(bus.F), 8'd7);
        chk("sat_noerr", 8'(bus.error), 8'd0);
        press(2);
        chk("sat_F_hold", 8'(bus.F), 8'd7);
        chk("sat_error", 8'(bus.error), 8'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_error", 8'(bus.error), 8'd0);
        bus.err_clr = 1'b1;
        bus.f_up = 1'b1;
        tick();
        chk("set_wins", 8'(bus.error), 8'd1);
        bus.err_clr = 1'b0;
        bus.f_up = 1'b0;
        tick();
        chk("sticky", 8'(bus.error), 8'd1);

        do_reset();
        repeat (4) press(1);
        chk("a_down_A0", 8'(bus.A), 8'd0);
        chk("a_down_A0f", 8'(bus.A0), 8'd1);
        chk("a_down_run", 8'(bus.busy), 8'd0);
        press(1);
        chk("a_under_A", 8'(bus.A), 8'd0);
        chk("a_under_err", 8'(bus.error), 8'd1);
        do_reset();
        bus.a_up = 1'b1;
        bus.a_down = 1'b1;
        tick();
        chk("a_both_A", 8'(bus.A), 8'd4);
        chk("a_both_err", 8'(bus.error), 8'd0);
        bus.a_up = 1'b0;
        bus.a_down = 1'b0;
        tick();
        repeat (3) press(0);
        chk("a_up_A7", 8'(bus.A), 8'd7);
        press(0);
        chk("a_over_A", 8'(bus.A), 8'd7);
        chk("a_over_err", 8'(bus.error), 8'd1);

        do_reset();
        repeat (3) press(3);
        bus.f_down = 1'b1;
        tick();
        chk("dec_F0", 8'(bus.F), 8'd0);
        chk("dec_F0f", 8'(bus.F0), 8'd1);
        chk("dec_nobusy", 8'(bus.busy), 8'd0);
        bus.f_down = 1'b0;
        tick();
        chk("dec_busy", 8'(bus.busy), 8'd1);
        repeat (3) tick();
        chk("dec_A4", 8'(bus.A), 8'd4);
        for (int i = 3; i >= 0; i--) begin
            tick();
            chk("dec_step", 8'(bus.A), 8'(i));
            if (i > 0) repeat (3) tick();
        end
        chk("dec_A0f", 8'(bus.A0), 8'd1);
        chk("dec_busy_A0", 8'(bus.busy), 8'd1);
        tick();
        chk("stop_busy", 8'(bus.busy), 8'd0);
        chk("stop_A", 8'(bus.A), 8'd0);
        press(3);
        chk("stop_fdown_err", 8'(bus.error), 8'd1);
        chk("stop_F", 8'(bus.F), 8'd0);
        press(0);
        repeat (5) tick();
        chk("stop_a_up", 8'(bus.A), 8'd1);
        chk("stop_nobusy", 8'(bus.busy), 8'd0);
        press(2);
        chk("stop_f_up", 8'(bus.F), 8'd1);
        chk("stop_run", 8'(bus.busy), 8'd0);

        do_reset();
        repeat (4) press(3);
        repeat (8) tick();
        chk("prio_A2", 8'(bus.A), 8'd2);
        chk("prio_busy", 8'(bus.busy), 8'd1);
        repeat (3) tick();
        bus.f_up = 1'b1;
        tick();
        chk("prio_F", 8'(bus.F), 8'd1);
        chk("prio_A", 8'(bus.A), 8'd2);
        chk("prio_run", 8'(bus.busy), 8'd0);
        bus.f_up = 1'b0;
        repeat (5) tick();
        chk("prio_nodecay", 8'(bus.A), 8'd2);

        do_reset();
        repeat (4) press(3);
        repeat (6) tick();
        chk("arst_pre_A", 8'(bus.A), 8'd3);
        reset = 1'b1;
        #1;
        chk("arst_A", 8'(bus.A), 8'd4);
        chk("arst_F", 8'(bus.F), 8'd4);
        chk("arst_busy", 8'(bus.busy), 8'd0);
        bus.f_up = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rel_held_F", 8'(bus.F), 8'd5);
        bus.f_up = 1'b0;
        tick();
        bus.f_up = 1'b1;
        bus.f_down = 1'b1;
        tick();
        chk("f_both_F", 8'(bus.F), 8'd5);
        chk("f_both_err", 8'(bus.error), 8'd0);
        bus.f_up = 1'b0;
        bus.f_down = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/amp_freq_ctrl.md
AMP_FREQ_CTRL -- requirements
Module: amp_freq_ctrl

Interface
REQ-001 Parameter WIDTH, default 3: bit width of A, F and their limits.
REQ-002 Parameter A_INIT, default 4: A value loaded at reset.
REQ-003 Parameter F_INIT, default 4: F value loaded at reset.
REQ-004 Parameter A_MAX, default 7: upper saturation limit of A, at most 2^WIDTH-1.
REQ-005 Parameter F_MAX, default 7: upper saturation limit of F, at most 2^WIDTH-1.
REQ-006 Parameter DECAY_DIV, default 4: clock cycles per automatic A decrement, at least 1.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 a_up  input  1  level request to increment A.
REQ-010 a_down  input  1  level request to decrement A.
REQ-011 f_up  input  1  level request to increment F.
REQ-012 f_down  input  1  level request to decrement F.
REQ-013 err_clr  input  1  clears the sticky error flag.
REQ-014 A  output  WIDTH  current amplitude, registered.
REQ-015 F  output  WIDTH  current frequency, registered.
REQ-016 F0  output  1  high when F==0 (combinational from register).
REQ-017 A0  output  1  high when A==0 (combinational from register).
REQ-018 busy  output  1  high while state is DECAY.
REQ-019 error  output  1  sticky error flag, registered.

Function
REQ-020 Each request input SHALL be edge-detected: it acts only at a clk edge where it is 1 and its value registered at the previous edge was 0. One press gives one step regardless of hold time.
REQ-021 A step SHALL be visible on A/F immediately after the clk edge at which the rising edge is detected, giving one-edge latency.
REQ-022 The FSM SHALL have states RUN, DECAY and STOPPED. The reset state is RUN.
REQ-023 RUN behaviour:
- f_up/f_down change F by +/-1.
- a_up/a_down change A by +/-1.
- If F==0 and A!=0, the next state is DECAY and the decay counter is cleared to 0.
- If F==0 and A==0, the next state is STOPPED.
REQ-024 DECAY behaviour:
- The decay counter increments every edge.
- When the counter equals DECAY_DIV-1, A decrements by 1 and the counter clears.
- a_up, a_down and f_down edges are ignored, with no change and no error.
REQ-025 DECAY exits:
- A==0 leads to STOPPED on the next edge.
- An f_up edge sets F=1, moves the state to RUN and clears the counter. This takes priority over a decrement due in the same cycle.
REQ-026 STOPPED behaviour:
- a_up/a_down act as in RUN.
- An f_up edge sets F=1 and moves the state to RUN.
- An f_down edge is an error.
REQ-027 Boundary errors: a step that would take A or F below 0, or above A_MAX/F_MAX, SHALL NOT be applied, and SHALL set error at the same edge.
REQ-028 Simultaneous rising edges on f_up and f_down in the same cycle SHALL be ignored with no error. The same applies to a_up and a_down.
REQ-029 Arithmetic SHALL NOT wrap. A and F stay within 0..A_MAX and 0..F_MAX at all times.
REQ-030 error SHALL stay at 1 until an edge where err_clr=1 and no new error occurs. If a set and a clear coincide, the set wins.
REQ-031 The decay counter SHALL be ceil(log2(DECAY_DIV+1)) bits wide. With DECAY_DIV=1, A decrements every edge in DECAY.

Reset
REQ-032 While reset=1, regardless of clk:
- A=A_INIT, F=F_INIT, state=RUN.
- Decay counter=0, error=0.
- All edge-detect registers=0.
REQ-033 Reset asserted mid-operation, including in DECAY, SHALL abort immediately to reset values. The first edge after release processes inputs normally. An input already held high at release counts as a rising edge.

Verification (defaults)
REQ-034 Reset pulse -> A=4, F=4, F0=0, A0=0, busy=0, error=0.
REQ-035 Four f_down presses from reset:
- F=0 and F0=1 after the 4th.
- busy=1 one edge later.
- A reaches 3, 2, 1, 0 at 4-edge intervals.
- STOPPED and busy=0 on the edge after A0=1.
REQ-036 f_up held high for 10 cycles -> F 4->5 only, error=0.
REQ-037 Saturation and error clear:
- Three f_up presses from reset give F=7.
- A fourth press leaves F=7 and sets error=1.
- err_clr for one cycle clears error to 0.
- err_clr coinciding with a new error leaves error=1.
REQ-038 In DECAY with A=2, an f_up press in the cycle a decrement is due -> F=1, A=2, state RUN, busy=0.
REQ-039 Reset asserted in DECAY -> A=4, F=4, busy=0 asynchronously. f_up and f_down rising in the same cycle -> F unchanged, error=0.
